// File: rtl/zxv_timing_pkg.sv
// Shared raster constants, fetch phase encodings and address helpers for the
// Pentagon video timing path.
package zxv_timing_pkg;

  localparam int ZX_H_TOTAL       = 448;
  localparam int ZX_V_TOTAL       = 320;
  localparam int ZX_H_ACTIVE      = 256;
  localparam int ZX_V_ACTIVE      = 192;
  localparam int DISP_DELAY       = 8;
  localparam int ZX_H_BLANK_START = 328;
  localparam int ZX_H_BLANK_LEN   = 64;
  localparam int ZX_H_SYNC_START  = 336;
  localparam int ZX_H_SYNC_LEN    = 32;
  localparam int ZX_V_SYNC_START  = 240;
  localparam int ZX_V_SYNC_LEN    = 4;
  localparam int ZX_V_BLANK_START = 240;
  localparam int ZX_V_BLANK_LEN   = 16;
  localparam int ZX_INT_LINE      = 239;
  localparam int ZX_INT_H         = 320;
  localparam int ZX_INT_LEN       = 32;
  localparam int ZX_FLASH_DIV_BIT = 4;

  // Address phases occupy the listed phase and the one after it.
  localparam logic [2:0] P_PIX_ADDR  = 3'd0;
  localparam logic [2:0] P_LD_PIX    = 3'd2;
  localparam logic [2:0] P_ATTR_ADDR = 3'd3;
  localparam logic [2:0] P_LD_ATTR   = 3'd5;
  localparam logic [2:0] P_LOAD      = 3'd7;

  localparam logic [2:0] ATTR_BASE = 3'b110;

  typedef struct packed {
    logic vs;
    logic hs;
    logic blank;
    logic border;
  } disp_t;

  localparam disp_t DISP_IDLE = '{vs: 1'b1, hs: 1'b1, blank: 1'b1, border: 1'b1};

  function automatic logic [12:0] pix_addr(input logic [7:0] v, input logic [4:0] col);
    return {v[7:6], v[2:0], v[5:3], col};
  endfunction

  function automatic logic [12:0] attr_addr(input logic [7:0] v, input logic [4:0] col);
    return {ATTR_BASE, v[7:3], col};
  endfunction

endpackage

// File: rtl/zxv_timing_if.sv
// Video fetch strobes and display control outputs of the timing sequencer.
interface zxv_timing_if;
  logic [12:0] VA;
  logic        VID_RD;
  logic        LD_PIX;
  logic        LD_ATTR;
  logic        LOAD;
  logic        BORDER;
  logic        BLANK;
  logic        HS;
  logic        VS;
  logic        INT;
  logic        FLASH;

  modport master (output VA, VID_RD, LD_PIX, LD_ATTR, LOAD, BORDER, BLANK, HS, VS, INT, FLASH);
  modport slave  (input  VA, VID_RD, LD_PIX, LD_ATTR, LOAD, BORDER, BLANK, HS, VS, INT, FLASH);
endinterface

// File: rtl/zxv_delay_line.sv
// Fixed-depth shift register that lines display controls up with the shifter.
module zxv_delay_line #(
  parameter int                 DATA_W     = 4,
  parameter int                 STAGES     = 8,
  parameter logic [DATA_W-1:0]  RESET_WORD = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] taps [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) taps[i] <= RESET_WORD;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < STAGES; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[STAGES-1];

endmodule

// File: rtl/zx_video_timing.sv
// Pentagon raster counters, video-memory fetch strobes and display control.
// Every output is registered from a decode of the counters' next state.
module zx_video_timing
  import zxv_timing_pkg::*;
#(
  parameter int H_TOTAL       = ZX_H_TOTAL,
  parameter int V_TOTAL       = ZX_V_TOTAL,
  parameter int V_ACTIVE      = ZX_V_ACTIVE,
  parameter int H_BLANK_START = ZX_H_BLANK_START,
  parameter int H_SYNC_START  = ZX_H_SYNC_START,
  parameter int H_SYNC_LEN    = ZX_H_SYNC_LEN,
  parameter int V_SYNC_START  = ZX_V_SYNC_START,
  parameter int V_SYNC_LEN    = ZX_V_SYNC_LEN,
  parameter int V_BLANK_START = ZX_V_BLANK_START,
  parameter int V_BLANK_LEN   = ZX_V_BLANK_LEN,
  parameter int INT_LINE      = ZX_INT_LINE,
  parameter int INT_H         = ZX_INT_H,
  parameter int INT_LEN       = ZX_INT_LEN,
  parameter int FLASH_DIV_BIT = ZX_FLASH_DIV_BIT
) (
  input  logic         CLK,
  input  logic         RESET,
  zxv_timing_if.master vif
);

  localparam logic [8:0] HT_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] VT_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT   = 9'(ZX_H_ACTIVE);
  localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
  localparam logic [8:0] HBS     = 9'(H_BLANK_START);
  localparam logic [8:0] HBE     = 9'(H_BLANK_START + ZX_H_BLANK_LEN);
  localparam logic [8:0] HSS     = 9'(H_SYNC_START);
  localparam logic [8:0] HSE     = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] VSS     = 9'(V_SYNC_START);
  localparam logic [8:0] VSE     = 9'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [8:0] VBS     = 9'(V_BLANK_START);
  localparam logic [8:0] VBE     = 9'(V_BLANK_START + V_BLANK_LEN);
  localparam logic [8:0] INT_V   = 9'(INT_LINE);
  localparam logic [8:0] INT_HS  = 9'(INT_H);
  localparam logic [8:0] INT_HE  = 9'(INT_H + INT_LEN);

  // Counters hold the raster position the output registers will show next.
  logic [8:0] h_nxt, v_nxt;
  logic [4:0] f_nxt;
  logic       h_wrap, v_wrap;

  assign h_wrap = (h_nxt == HT_LAST);
  assign v_wrap = (v_nxt == VT_LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h_nxt <= '0;
      v_nxt <= '0;
      f_nxt <= '0;
    end else begin
      h_nxt <= h_wrap ? 9'd0 : h_nxt + 9'd1;
      if (h_wrap) begin
        v_nxt <= v_wrap ? 9'd0 : v_nxt + 9'd1;
        if (v_wrap) f_nxt <= f_nxt + 5'd1;
      end
    end
  end

  logic       in_fetch, pix_phase, attr_phase, int_nxt;
  logic [2:0] phase;
  logic [4:0] col;
  disp_t      disp_nxt;

  always_comb begin
    in_fetch   = (v_nxt < V_ACT) && (h_nxt < H_ACT);
    phase      = h_nxt[2:0];
    col        = h_nxt[7:3];
    pix_phase  = in_fetch && (phase == P_PIX_ADDR || phase == P_PIX_ADDR + 3'd1);
    attr_phase = in_fetch && (phase == P_ATTR_ADDR || phase == P_ATTR_ADDR + 3'd1);
    // Undelayed display decode: raw counters, later shifted by the delay line.
    disp_nxt.border = !in_fetch;
    disp_nxt.blank  = (h_nxt >= HBS && h_nxt < HBE) || (v_nxt >= VBS && v_nxt < VBE);
    disp_nxt.hs     = !(h_nxt >= HSS && h_nxt < HSE);
    disp_nxt.vs     = !(v_nxt >= VSS && v_nxt < VSE);
    int_nxt         = !(v_nxt == INT_V && h_nxt >= INT_HS && h_nxt < INT_HE);
  end

  // Stage p0: registered fetch strobes and undelayed display word.
  logic [12:0] va_p0;
  logic        vid_rd_p0, ld_pix_p0, ld_attr_p0, load_p0, int_p0, flash_p0;
  disp_t       disp_p0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      va_p0      <= '0;
      vid_rd_p0  <= 1'b0;
      ld_pix_p0  <= 1'b0;
      ld_attr_p0 <= 1'b0;
      load_p0    <= 1'b0;
      int_p0     <= 1'b1;
      flash_p0   <= 1'b0;
      disp_p0    <= DISP_IDLE;
    end else begin
      if (pix_phase)       va_p0 <= pix_addr(v_nxt[7:0], col);
      else if (attr_phase) va_p0 <= attr_addr(v_nxt[7:0], col);
      vid_rd_p0  <= pix_phase || attr_phase;
      ld_pix_p0  <= in_fetch && (phase == P_LD_PIX);
      ld_attr_p0 <= in_fetch && (phase == P_LD_ATTR);
      load_p0    <= in_fetch && (phase == P_LOAD);
      int_p0     <= int_nxt;
      flash_p0   <= f_nxt[FLASH_DIV_BIT];
      disp_p0    <= disp_nxt;
    end
  end

  // Stage p8: display controls aligned with the shifter output.
  logic [3:0] disp_p8_vec;
  disp_t      disp_p8;

  zxv_delay_line #(
    .DATA_W     (4),
    .STAGES     (DISP_DELAY),
    .RESET_WORD (DISP_IDLE)
  ) u_disp_dly (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (disp_p0),
    .q     (disp_p8_vec)
  );

  assign disp_p8 = disp_t'(disp_p8_vec);

  assign vif.VA      = va_p0;
  assign vif.VID_RD  = vid_rd_p0;
  assign vif.LD_PIX  = ld_pix_p0;
  assign vif.LD_ATTR = ld_attr_p0;
  assign vif.LOAD    = load_p0;
  assign vif.INT     = int_p0;
  assign vif.FLASH   = flash_p0;
  assign vif.BORDER  = disp_p8.border;
  assign vif.BLANK   = disp_p8.blank;
  assign vif.HS      = disp_p8.hs;
  assign vif.VS      = disp_p8.vs;

endmodule
